change_dispenser: RTL and testbench

Sequences the coin-return mechanism of the vending machine. The main controller hands it a refund amount in half-yuan units. It pays the amount out one coin per handshake, greedy largest-first, from per-denomination coin stocks. It reports completion and any unpaid remainder (shortfall) back to the controller.

---
 rtl/change_dispenser_pkg.sv | 33 +++
 rtl/change_dispenser_coin_select.sv | 28 ++
 rtl/change_dispenser.sv | 179 +++++++++++++++++
 tb/tb_change_dispenser.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared types for the coin-return path: coin denominations, their values in
// half-yuan units, and the dispenser state encoding.
package change_dispenser_pkg;

  typedef enum logic [1:0] {
    COIN_0P5 = 2'd0,
    COIN_1   = 2'd1,
    COIN_5   = 2'd2,
    COIN_10  = 2'd3
  } coin_t;

  localparam int NUM_COINS  = 4;
  localparam int COIN_VAL_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_GAP,
    ST_DONE
  } disp_state_t;

  // Face value of a coin in 0.5 CNY units.
  function automatic logic [COIN_VAL_W-1:0] coin_val(input coin_t coin);
    case (coin)
      COIN_10: return 5'd20;
      COIN_5:  return 5'd10;
      COIN_1:  return 5'd2;
      default: return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Combinational greedy picker: largest coin whose value fits in the remaining
// amount and whose stock is non-empty.
module coin_select
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic [AMT_W-1:0]     remaining_i,
  input  logic [NUM_COINS-1:0] stock_nz_i,
  output logic                 found_o,
  output coin_t                coin_o
);

  // Scan smallest to largest so the last eligible denomination wins.
  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    found_o = 1'b0;
    coin_o  = COIN_0P5;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (stock_nz_i[i] &&
          (32'(coin_val(coin_t'(i[1:0]))) <= 32'(remaining_i))) begin
        found_o = 1'b1;
        coin_o  = coin_t'(i[1:0]);
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Coin-return sequencer: pays a refund one coin per eject handshake, greedy
// largest-first, from per-denomination stocks, then reports any shortfall.
// Optional macro CHANGE_TIMEOUT_EN adds an eject_ack timeout that flags a jam,
// empties the jammed denomination and continues with smaller coins.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W       = 8,
  parameter int STOCK_W     = 6,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [AMT_W-1:0]   req_amount,
  output logic               req_ready,
  input  logic               load_en,
  input  coin_t              load_coin,
  input  logic [STOCK_W-1:0] load_count,
  output logic               eject_valid,
  output coin_t              eject_coin,
  input  logic               eject_ack,
  output logic               busy,
  output logic               done,
  output logic [AMT_W-1:0]   shortfall,
  output logic               jam
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  disp_state_t        state_q;
  logic [AMT_W-1:0]   remaining_q;
  logic [STOCK_W-1:0] stock_q [NUM_COINS];
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               eject_valid_q;
  coin_t              eject_coin_q;
  logic               done_q;
  logic [AMT_W-1:0]   shortfall_q;

`ifdef CHANGE_TIMEOUT_EN
  localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  logic [ACK_W-1:0]   ack_cnt_q;
  logic               jam_q;
`endif

  logic [NUM_COINS-1:0] stock_nz;
  logic                 sel_found;
  coin_t                sel_coin;

  // Flag which denominations still have coins available.
  always_comb begin
    for (int i = 0; i < NUM_COINS; i++) begin
      stock_nz[i] = (stock_q[i] != '0);
    end
  end

  coin_select #(
    .AMT_W (AMT_W)
  ) u_coin_select (
    .remaining_i (remaining_q),
    .stock_nz_i  (stock_nz),
    .found_o     (sel_found),
    .coin_o      (sel_coin)
  );

  // Dispenser FSM with stock bookkeeping and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      remaining_q   <= '0;
      // NOTE: the stock array is cleared on reset because an aborted refund must not leave stale counts behind.
      for (int i = 0; i < NUM_COINS; i++) begin
        stock_q[i] <= '0;
      end
      gap_cnt_q     <= '0;
      eject_valid_q <= 1'b0;
      eject_coin_q  <= COIN_0P5;
      done_q        <= 1'b0;
      shortfall_q   <= '0;
`ifdef CHANGE_TIMEOUT_EN
      ack_cnt_q     <= '0;
      jam_q         <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register update in step with the clock edge.
      done_q <= 1'b0;
`ifdef CHANGE_TIMEOUT_EN
      jam_q  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (load_en) begin
            stock_q[load_coin] <= load_count;
          end
          if (req_valid) begin
            remaining_q <= req_amount;
            shortfall_q <= '0;
            state_q     <= ST_SELECT;
          end
        end

        ST_SELECT: begin
          if (remaining_q == '0) begin
            shortfall_q <= '0;
            done_q      <= 1'b1;
            state_q     <= ST_DONE;
          end else if (!sel_found) begin
            shortfall_q <= remaining_q;
            done_q      <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            eject_coin_q  <= sel_coin;
            eject_valid_q <= 1'b1;
`ifdef CHANGE_TIMEOUT_EN
            ack_cnt_q     <= '0;
`endif
            state_q       <= ST_EJECT;
          end
        end

        ST_EJECT: begin
          if (eject_ack) begin
            remaining_q           <= remaining_q - AMT_W'(coin_val(eject_coin_q));
            stock_q[eject_coin_q] <= stock_q[eject_coin_q] - STOCK_W'(1);
            eject_valid_q         <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state_q <= ST_SELECT;
            end else begin
              gap_cnt_q <= GAP_W'(GAP_CYCLES - 1);
              state_q   <= ST_GAP;
            end
          end
`ifdef CHANGE_TIMEOUT_EN
          else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
            // Treat the denomination as jammed: stop using it, keep the balance.
            jam_q                 <= 1'b1;
            stock_q[eject_coin_q] <= '0;
            eject_valid_q         <= 1'b0;
            state_q               <= ST_SELECT;
          end else begin
            ack_cnt_q <= ack_cnt_q + ACK_W'(1);
          end
`endif
        end

        ST_GAP: begin
          if (gap_cnt_q == '0) begin
            state_q <= ST_SELECT;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign eject_valid = eject_valid_q;
  assign eject_coin  = eject_coin_q;
  assign done        = done_q;
  assign shortfall   = shortfall_q;

`ifdef CHANGE_TIMEOUT_EN
  assign jam = jam_q;
`else
  assign jam = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: table-driven refunds, hand-written
// reset/timeout sequences and randomized refunds against a greedy count model.
module tb_change_dispenser;
  import change_dispenser_pkg::*;

  localparam int AMT_W       = 8;
  localparam int STOCK_W     = 6;
  localparam int GAP_CYCLES  = 2;
  localparam int ACK_TIMEOUT = 8;
`ifdef CHANGE_TIMEOUT_EN
  localparam int LONG_WAIT = ACK_TIMEOUT - 2;
`else
  localparam int LONG_WAIT = 10;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid;
  logic [AMT_W-1:0]   req_amount;
  logic               req_ready;
  logic               load_en;
  coin_t              load_coin;
  logic [STOCK_W-1:0] load_count;
  logic               eject_valid;
  coin_t              eject_coin;
  logic               eject_ack;
  logic               busy;
  logic               done;
  logic [AMT_W-1:0]   shortfall;
  logic               jam;

  change_dispenser #(
    .AMT_W       (AMT_W),
    .STOCK_W     (STOCK_W),
    .GAP_CYCLES  (GAP_CYCLES),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_amount  (req_amount),
    .req_ready   (req_ready),
    .load_en     (load_en),
    .load_coin   (load_coin),
    .load_count  (load_count),
    .eject_valid (eject_valid),
    .eject_coin  (eject_coin),
    .eject_ack   (eject_ack),
    .busy        (busy),
    .done        (done),
    .shortfall   (shortfall),
    .jam         (jam)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Values indexed by coin encoding: 0.5, 1, 5, 10 yuan in half-yuan units.
  int coin_value [4] = '{1, 2, 10, 20};
  int model_stock [4];
  int exp_q [$];
  int exp_short;

  typedef struct {
    int s05;
    int s1;
    int s5;
    int s10;
    int amount;
    int ack_delay;
    bit poke;
    int exp_short;
    int drain_short;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Greedy payout by counts: take as many of each coin as fit, largest first.
  task automatic model_refund(input int amount);
    int rem;
    rem = amount;
    exp_q.delete();
    for (int c = 3; c >= 0; c--) begin
      int n;
      n = rem / coin_value[c];
      if (n > model_stock[c]) n = model_stock[c];
      rem = rem - n * coin_value[c];
      model_stock[c] = model_stock[c] - n;
      repeat (n) exp_q.push_back(c);
    end
    exp_short = rem;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_amount = '0;
    load_en    = 1'b0;
    load_coin  = COIN_0P5;
    load_count = '0;
    eject_ack  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model_stock[i] = 0;
  endtask

  task automatic load(input int c, input int n);
    load_en    = 1'b1;
    load_coin  = coin_t'(c[1:0]);
    load_count = STOCK_W'(n);
    @(negedge clk);
    load_en = 1'b0;
    model_stock[c] = n;
  endtask

  // Issue one refund from IDLE and follow it to completion, acking each coin
  // after ack_delay cycles (negative = random 0..3).
  task automatic run_refund(input int amount, input int ack_delay, input bit poke,
                            input bit sim_en, input int sim_coin, input int sim_count,
                            output int short_got);
    int  k, wait_n, delay, cur_coin, last_ack_k, exp_k, n_ej, n_exp;
    bit  in_eject, finished;
    if (sim_en) model_stock[sim_coin] = sim_count;
    model_refund(amount);
    n_exp     = exp_q.size();
    short_got = -1;
    check("req_ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_amount = AMT_W'(amount);
    if (sim_en) begin
      load_en    = 1'b1;
      load_coin  = coin_t'(sim_coin[1:0]);
      load_count = STOCK_W'(sim_count);
    end
    @(negedge clk);
    req_valid = 1'b0;
    load_en   = 1'b0;
    check("busy_after_accept", busy, 1);
    k = 1; wait_n = 0; delay = 0; cur_coin = 0; last_ack_k = -1; n_ej = 0;
    in_eject = 1'b0; finished = 1'b0;
    while (!finished && k < 2000) begin
      eject_ack = 1'b0;
      if (poke) begin
        load_en    = 1'b1;
        load_coin  = COIN_10;
        load_count = '1;
      end
      if (done) begin
        finished = 1'b1;
        exp_k = (last_ack_k < 0) ? 2 : last_ack_k + GAP_CYCLES + 2;
        check("done_latency", k, exp_k);
        check("shortfall", shortfall, exp_short);
        check("no_eject_at_done", eject_valid, 0);
        check("eject_count", n_ej, n_exp);
        check("jam_quiet", jam, 0);
        short_got = int'(shortfall);
      end else if (eject_valid) begin
        if (!in_eject) begin
          in_eject = 1'b1;
          wait_n   = 0;
          cur_coin = int'(eject_coin);
          delay    = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
          exp_k    = (last_ack_k < 0) ? 2 : last_ack_k + GAP_CYCLES + 2;
          check("eject_latency", k, exp_k);
          n_ej++;
          if (exp_q.size() > 0) check("eject_coin", eject_coin, exp_q.pop_front());
        end else begin
          check("eject_coin_stable", eject_coin, cur_coin);
        end
        if (wait_n == delay) begin
          eject_ack  = 1'b1;
          in_eject   = 1'b0;
          last_ack_k = k;
        end else begin
          wait_n++;
        end
      end else begin
        if (in_eject) check("eject_held_until_ack", eject_valid, 1);
        // Acks outside an ejection must be ignored.
        eject_ack = ($urandom_range(0, 3) == 0);
      end
      if (!finished) begin
        @(negedge clk);
        k++;
      end
    end
    eject_ack = 1'b0;
    load_en   = 1'b0;
    check("done_seen", finished, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_after_done", req_ready, 1);
    check("busy_after_done", busy, 0);
    check("shortfall_held", shortfall, exp_short);
  endtask

  initial begin
    int got, amt, sc, sn, total, n, cnt;
    bit sim, fin;

    vecs[0] = '{1, 3, 1, 2,  35, 1,         1'b1, 0, 233};
    vecs[1] = '{0, 1, 0, 0,   7, 0,         1'b0, 5, 255};
    vecs[2] = '{2, 2, 2, 2,   0, 0,         1'b0, 0, 189};
    vecs[3] = '{0, 5, 0, 0,   3, LONG_WAIT, 1'b0, 1, 247};
    vecs[4] = '{3, 0, 1, 0,  21, 2,         1'b0, 8, 255};
    vecs[5] = '{1, 1, 1, 12, 255, 0,        1'b0, 2, 255};

    // Reset values.
    do_reset();
    check("rst_eject_valid", eject_valid, 0);
    check("rst_eject_coin", eject_coin, COIN_0P5);
    check("rst_done", done, 0);
    check("rst_jam", jam, 0);
    check("rst_shortfall", shortfall, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 1);

    // Directed table: each row refunds, then a 255 request drains what is left.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      load(0, vecs[r].s05);
      load(1, vecs[r].s1);
      load(2, vecs[r].s5);
      load(3, vecs[r].s10);
      run_refund(vecs[r].amount, vecs[r].ack_delay, vecs[r].poke, 1'b0, 0, 0, got);
      check($sformatf("vec%0d_short", r), got, vecs[r].exp_short);
      run_refund(255, 0, 1'b0, 1'b0, 0, 0, got);
      check($sformatf("vec%0d_drain", r), got, vecs[r].drain_short);
    end

    // Reset in the middle of an ejection aborts cleanly and empties stocks.
    do_reset();
    load(3, 2);
    load(1, 3);
    req_valid  = 1'b1;
    req_amount = 8'd45;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!eject_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_in_eject", eject_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model_stock[i] = 0;
    check("rstmid_eject_valid", eject_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_shortfall", shortfall, 0);
    for (int i = 0; i < 3; i++) begin
      check("rstmid_no_done", done, 0);
      @(negedge clk);
    end
    run_refund(255, 0, 1'b0, 1'b0, 0, 0, got);
    check("rstmid_drain", got, 255);

`ifdef CHANGE_TIMEOUT_EN
    // Never ack the 5: jam after ACK_TIMEOUT cycles, then pay with 1s.
    do_reset();
    load(2, 1);
    load(1, 5);
    req_valid  = 1'b1;
    req_amount = 8'd10;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!eject_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("to_first_coin", eject_coin, COIN_5);
    cnt = 0;
    while (eject_valid && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("to_wait_cycles", cnt, ACK_TIMEOUT);
    check("to_jam_pulse", jam, 1);
    cnt = 0; n = 0; fin = 1'b0;
    while (!fin && n < 200) begin
      eject_ack = 1'b0;
      if (n == 1) check("to_jam_one_cycle", jam, 0);
      if (done) begin
        fin = 1'b1;
        check("to_shortfall", shortfall, 0);
      end else if (eject_valid) begin
        check("to_coin1", eject_coin, COIN_1);
        eject_ack = 1'b1;
        cnt++;
      end
      if (!fin) begin
        @(negedge clk);
        n++;
      end
    end
    eject_ack = 1'b0;
    check("to_done", fin, 1);
    check("to_coin1_count", cnt, 5);
    @(negedge clk);
    do_reset();
`endif

    // Randomized refunds against the count model, with occasional loads
    // alongside the request and loads attempted while busy.
    for (int it = 0; it < 25; it++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 1) == 1) load(c, int'($urandom_range(0, 3)));
      end
      sim = ($urandom_range(0, 3) == 0);
      sc  = int'($urandom_range(0, 3));
      sn  = int'($urandom_range(0, 3));
      amt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 60));
      run_refund(amt, -1, ($urandom_range(0, 4) == 0), sim, sc, sn, got);
    end
    total = 0;
    for (int c = 0; c < 4; c++) total += model_stock[c] * coin_value[c];
    run_refund(255, -1, 1'b0, 1'b0, 0, 0, got);
    check("rand_drain", got, 255 - total);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
